// File: rtl/retire_packer.sv
// Packs a single-instruction retirement stream into multi-lane retire bundles.
// Optional performance counters are enabled with `define RETIRE_PACKER_PERF_EN.

package mure_pkg;
    localparam int unsigned XLEN      = 32;
    localparam int unsigned INST_LEN  = 32;
    localparam int unsigned CAUSE_LEN = 5;
endpackage

module retire_packer #(
    parameter int unsigned NrRetiredInstr = 2,
    parameter int unsigned Timeout        = 8
) (
    input  logic                                           clk_i,
    input  logic                                           rst_ni,
    input  logic                                           inst_valid_i,
    output logic                                           ready_o,
    input  logic                                           iretired_i,
    input  logic [mure_pkg::INST_LEN-1:0]                  inst_data_i,
    input  logic [mure_pkg::XLEN-1:0]                      pc_i,
    input  logic                                           exception_i,
    input  logic                                           interrupt_i,
    input  logic [mure_pkg::CAUSE_LEN-1:0]                 cause_i,
    input  logic [mure_pkg::XLEN-1:0]                      tval_i,
    output logic                                           bundle_valid_o,
    input  logic                                           bundle_ready_i,
    output logic [NrRetiredInstr-1:0]                      valids_o,
    output logic [NrRetiredInstr*mure_pkg::INST_LEN-1:0]   uops_o,
    output logic [NrRetiredInstr*mure_pkg::XLEN-1:0]       pcs_o,
    output logic                                           exception_o,
    output logic                                           interrupt_o,
    output logic [mure_pkg::CAUSE_LEN-1:0]                 cause_o,
    output logic [mure_pkg::XLEN-1:0]                      tval_o
`ifdef RETIRE_PACKER_PERF_EN
    ,
    output logic [31:0]                                    bundle_cnt_o,
    output logic [31:0]                                    timeout_cnt_o
`endif
);
    import mure_pkg::*;

    localparam int unsigned CntW  = $clog2(NrRetiredInstr + 1);
    localparam int unsigned LaneW = (NrRetiredInstr > 1) ? $clog2(NrRetiredInstr) : 1;
    localparam int unsigned IdleW = (Timeout > 1) ? $clog2(Timeout) : 1;

    typedef enum logic [1:0] {IDLE, FILL, CLOSED} state_e;

    typedef struct packed {
        logic [NrRetiredInstr-1:0]                valids;
        logic [NrRetiredInstr-1:0][INST_LEN-1:0]  uops;
        logic [NrRetiredInstr-1:0][XLEN-1:0]      pcs;
        logic                                     exception;
        logic                                     interrupt;
        logic [CAUSE_LEN-1:0]                     cause;
        logic [XLEN-1:0]                          tval;
    } bundle_t;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d, cnt_next;
    logic [IdleW-1:0]    idle_q, idle_d;
    bundle_t             acc_q, acc_d, merged;
    bundle_t             out_q, out_d;
    logic                out_valid_q, out_valid_d;
    logic                accept, timeout_fire, close, out_free, load;
    logic [LaneW-1:0]    lane;

    assign ready_o  = (state_q != CLOSED);
    assign accept   = inst_valid_i && ready_o;
    assign out_free = !out_valid_q || bundle_ready_i;
    assign lane     = cnt_q[LaneW-1:0];
    assign cnt_next = cnt_q + CntW'(accept && iretired_i);

    assign timeout_fire = (Timeout != 0) && (state_q == FILL) && !accept &&
                          (idle_q == IdleW'(Timeout - 1));
    assign close = (accept && ((cnt_next == CntW'(NrRetiredInstr)) || exception_i)) ||
                   timeout_fire;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        merged      = acc_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        idle_d      = '0;
        acc_d       = acc_q;
        out_d       = out_q;
        out_valid_d = out_valid_q && !bundle_ready_i;
        load        = 1'b0;

        if (accept && iretired_i) begin
            merged.valids[lane] = 1'b1;
            merged.uops[lane]   = inst_data_i;
            merged.pcs[lane]    = pc_i;
        end
        // Interrupt qualifies a trap only; on its own it carries no meaning.
        if (accept && exception_i) begin
            merged.exception = 1'b1;
            merged.interrupt = interrupt_i;
            merged.cause     = cause_i;
            merged.tval      = tval_i;
        end

        if (state_q == CLOSED) begin
            if (out_free) begin
                out_d   = acc_q;
                load    = 1'b1;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        end else if (close) begin
            cnt_d = '0;
            if (out_free) begin
                out_d   = merged;
                load    = 1'b1;
                acc_d   = '0;
                state_d = IDLE;
            end else begin
                acc_d   = merged;
                state_d = CLOSED;
            end
        end else begin
            acc_d   = merged;
            cnt_d   = cnt_next;
            state_d = (cnt_next == '0) ? IDLE : FILL;
            if (state_q == FILL && !accept) idle_d = idle_q + IdleW'(1);
        end

        if (load) out_valid_d = 1'b1;
    end

    // NOTE: state uses non-blocking assignments; the accumulator and output register are
    // reset too, so a bundle interrupted by reset never leaks stale lanes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idle_q      <= '0;
            acc_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idle_q      <= idle_d;
            acc_q       <= acc_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bundle_valid_o = out_valid_q;
    assign valids_o       = out_q.valids;
    assign uops_o         = out_q.uops;
    assign pcs_o          = out_q.pcs;
    assign exception_o    = out_q.exception;
    assign interrupt_o    = out_q.interrupt;
    assign cause_o        = out_q.cause;
    assign tval_o         = out_q.tval;

`ifdef RETIRE_PACKER_PERF_EN
    logic [31:0] bundle_cnt_q, timeout_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bundle_cnt_q  <= '0;
            timeout_cnt_q <= '0;
        end else begin
            if (load)         bundle_cnt_q  <= bundle_cnt_q + 32'd1;
            if (timeout_fire) timeout_cnt_q <= timeout_cnt_q + 32'd1;
        end
    end

    assign bundle_cnt_o  = bundle_cnt_q;
    assign timeout_cnt_o = timeout_cnt_q;
`endif

endmodule

// File: tb/tb_retire_packer.sv
// Self-checking bench for retire_packer: directed test-plan steps followed by
// randomized traffic, checked against a queue-based bundle model.

module tb_retire_packer;
    import mure_pkg::*;

    localparam int unsigned NR = 2;
    localparam int unsigned TO = 8;

    logic                     clk = 1'b0;
    logic                     rst_ni = 1'b0;
    logic                     inst_valid_i = 1'b0, iretired_i = 1'b0;
    logic [INST_LEN-1:0]      inst_data_i = '0;
    logic [XLEN-1:0]          pc_i = '0, tval_i = '0;
    logic                     exception_i = 1'b0, interrupt_i = 1'b0;
    logic [CAUSE_LEN-1:0]     cause_i = '0;
    logic                     bundle_ready_i = 1'b1;
    logic                     ready_o, bundle_valid_o, exception_o, interrupt_o;
    logic [NR-1:0]            valids_o;
    logic [NR*INST_LEN-1:0]   uops_o;
    logic [NR*XLEN-1:0]       pcs_o;
    logic [CAUSE_LEN-1:0]     cause_o;
    logic [XLEN-1:0]          tval_o;
`ifdef RETIRE_PACKER_PERF_EN
    logic [31:0]              bundle_cnt_o, timeout_cnt_o;
`endif

    retire_packer #(.NrRetiredInstr(NR), .Timeout(TO)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .inst_valid_i(inst_valid_i), .ready_o(ready_o), .iretired_i(iretired_i),
        .inst_data_i(inst_data_i), .pc_i(pc_i), .exception_i(exception_i),
        .interrupt_i(interrupt_i), .cause_i(cause_i), .tval_i(tval_i),
        .bundle_valid_o(bundle_valid_o), .bundle_ready_i(bundle_ready_i),
        .valids_o(valids_o), .uops_o(uops_o), .pcs_o(pcs_o),
        .exception_o(exception_o), .interrupt_o(interrupt_o),
        .cause_o(cause_o), .tval_o(tval_o)
`ifdef RETIRE_PACKER_PERF_EN
        , .bundle_cnt_o(bundle_cnt_o), .timeout_cnt_o(timeout_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NR-1:0]          valids;
        logic [NR*INST_LEN-1:0] uops;
        logic [NR*XLEN-1:0]     pcs;
        logic                   exc;
        logic                   intr;
        logic [CAUSE_LEN-1:0]   cause;
        logic [XLEN-1:0]        tval;
    } mb_t;

    int n_cmp = 0;
    int n_err = 0;

    // Model: lanes of the open bundle, a bundle closed but not yet handed off,
    // and the bundle currently presented at the output.
    logic [XLEN-1:0]     q_pc[$];
    logic [INST_LEN-1:0] q_uop[$];
    bit                  m_held, m_out_valid;
    mb_t                 m_held_b, m_out;
    int                  m_idle, m_bundles, m_timeouts;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q_pc.delete();
        q_uop.delete();
        m_held = 0; m_out_valid = 0; m_held_b = '0; m_out = '0;
        m_idle = 0; m_bundles = 0; m_timeouts = 0;
    endtask

    function automatic mb_t build(input bit exc, input bit intr,
                                  input logic [CAUSE_LEN-1:0] cause, input logic [XLEN-1:0] tval);
        mb_t b = '0;
        for (int i = 0; i < q_pc.size(); i++) begin
            b.valids[i]                  = 1'b1;
            b.pcs[i*XLEN +: XLEN]        = q_pc[i];
            b.uops[i*INST_LEN +: INST_LEN] = q_uop[i];
        end
        if (exc) begin
            b.exc = 1'b1; b.intr = intr; b.cause = cause; b.tval = tval;
        end
        return b;
    endfunction

    task automatic model_step(input bit v, input bit ir, input logic [INST_LEN-1:0] uop,
                              input logic [XLEN-1:0] pc, input bit exc, input bit intr,
                              input logic [CAUSE_LEN-1:0] cause, input logic [XLEN-1:0] tval,
                              input bit br);
        bit  out_free = !m_out_valid || br;
        bit  acc = v && !m_held;
        bit  load = 0;
        bit  was_open, tmo;
        mb_t nb = '0;
        if (m_held) begin
            if (out_free) begin nb = m_held_b; load = 1; m_held = 0; end
        end else begin
            was_open = q_pc.size() > 0;
            tmo = (TO != 0) && was_open && !acc && (m_idle == TO - 1);
            if (acc && ir) begin q_pc.push_back(pc); q_uop.push_back(uop); end
            if ((acc && (q_pc.size() == NR || exc)) || tmo) begin
                nb = build(acc && exc, intr, cause, tval);
                q_pc.delete(); q_uop.delete();
                m_idle = 0;
                if (tmo) m_timeouts++;
                if (out_free) load = 1;
                else begin m_held = 1; m_held_b = nb; end
            end else if (was_open && !acc) m_idle++;
            else m_idle = 0;
        end
        if (load) begin m_out = nb; m_out_valid = 1; m_bundles++; end
        else if (br) m_out_valid = 0;
    endtask

    task automatic compare_outputs();
        check("ready", ready_o, !m_held);
        check("bundle_valid", bundle_valid_o, m_out_valid);
        if (m_out_valid) begin
            check("valids", valids_o, m_out.valids);
            for (int i = 0; i < NR; i++) begin
                if (m_out.valids[i]) begin
                    check($sformatf("pc%0d", i), pcs_o[i*XLEN +: XLEN], m_out.pcs[i*XLEN +: XLEN]);
                    check($sformatf("uop%0d", i), uops_o[i*INST_LEN +: INST_LEN],
                          m_out.uops[i*INST_LEN +: INST_LEN]);
                end
            end
            check("exception", exception_o, m_out.exc);
            check("interrupt", interrupt_o, m_out.intr);
            check("cause", cause_o, m_out.cause);
            check("tval", tval_o, m_out.tval);
        end
`ifdef RETIRE_PACKER_PERF_EN
        check("bundle_cnt", bundle_cnt_o, m_bundles);
        check("timeout_cnt", timeout_cnt_o, m_timeouts);
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bvalid"}, bundle_valid_o, 1'b0);
        check({tag, "_ready"}, ready_o, 1'b1);
        check({tag, "_valids"}, valids_o, '0);
        check({tag, "_uops"}, uops_o, '0);
        check({tag, "_pcs"}, pcs_o, '0);
        check({tag, "_trap"}, {exception_o, interrupt_o, cause_o, tval_o}, '0);
`ifdef RETIRE_PACKER_PERF_EN
        check({tag, "_perf"}, {bundle_cnt_o, timeout_cnt_o}, '0);
`endif
    endtask

    // One clock: drive at the falling edge, DUT samples on the rising edge,
    // outputs compared at the next falling edge.
    task automatic cycle(input bit v, input bit ir, input logic [INST_LEN-1:0] uop,
                         input logic [XLEN-1:0] pc, input bit exc, input bit intr,
                         input logic [CAUSE_LEN-1:0] cause, input logic [XLEN-1:0] tval,
                         input bit br);
        inst_valid_i = v; iretired_i = ir; inst_data_i = uop; pc_i = pc;
        exception_i = exc; interrupt_i = intr; cause_i = cause; tval_i = tval;
        bundle_ready_i = br;
        model_step(v, ir, uop, pc, exc, intr, cause, tval, br);
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic rec(input logic [XLEN-1:0] pc, input bit br);
        cycle(1, 1, pc ^ 32'h1300_0013, pc, 0, 0, '0, '0, br);
    endtask

    task automatic idle(input bit br);
        cycle(0, 0, '0, '0, 0, 0, '0, '0, br);
    endtask

    initial begin
        int p;
        model_reset();
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_ni = 1'b1;

        // Two back-to-back records form one full bundle.
        rec(32'h100, 1);
        check("t1_early", bundle_valid_o, 1'b0);
        rec(32'h104, 1);
        check("t1_valid", bundle_valid_o, 1'b1);
        check("t1_valids", valids_o, 2'b11);
        check("t1_pcs", pcs_o, {32'h104, 32'h100});
        idle(1);

        // A lone record closes after Timeout idle cycles.
        rec(32'h200, 1);
        for (int k = 1; k <= 8; k++) begin
            idle(1);
            check($sformatf("t2_idle%0d", k), bundle_valid_o, k == 8);
        end
        check("t2_valids", valids_o, 2'b01);
        check("t2_pc", pcs_o[XLEN-1:0], 32'h200);
`ifdef RETIRE_PACKER_PERF_EN
        check("t2_tmo_cnt", timeout_cnt_o, 32'd1);
`endif
        idle(1);

        // Excepting record closes the bundle immediately.
        cycle(1, 1, 32'h0000_0073, 32'h300, 1, 0, 5'd2, 32'hDEAD, 1);
        check("t3_valid", bundle_valid_o, 1'b1);
        check("t3_valids", valids_o, 2'b01);
        check("t3_trap", {exception_o, interrupt_o, cause_o, tval_o}, {1'b1, 1'b0, 5'd2, 32'hDEAD});
        idle(1);

        // Back-pressure: first bundle holds, second closes into CLOSED.
        rec(32'h400, 0);
        rec(32'h404, 0);
        rec(32'h408, 0);
        check("t4_hold_pcs", pcs_o, {32'h404, 32'h400});
        rec(32'h40C, 0);
        check("t4_closed_ready", ready_o, 1'b0);
        check("t4_hold_pcs2", pcs_o, {32'h404, 32'h400});
        rec(32'h410, 0);
        rec(32'h410, 1);
        check("t4_second_pcs", pcs_o, {32'h40C, 32'h408});
        rec(32'h410, 1);
        rec(32'h414, 1);
        check("t4_third_pcs", pcs_o, {32'h414, 32'h410});
        idle(1);

        // Trap-only record occupies no lane.
        cycle(1, 0, '0, 32'h500, 1, 1, 5'd7, 32'h1234, 1);
        check("t5_valids", valids_o, 2'b00);
        check("t5_exc_int", {exception_o, interrupt_o}, 2'b11);
        idle(1);

        // Reset mid-bundle with a bundle on the output and one lane open.
        rec(32'h500, 0);
        rec(32'h504, 0);
        rec(32'h508, 0);
        check("t6_pre_valid", bundle_valid_o, 1'b1);
        #2 rst_ni = 1'b0;
        #1 check_all_zero("t6_async");
        @(negedge clk);
        rst_ni = 1'b1;
        model_reset();
        rec(32'h600, 1);
        rec(32'h604, 1);
        check("t6_fresh_pcs", pcs_o, {32'h604, 32'h600});
        check("t6_fresh_valids", valids_o, 2'b11);
        idle(1);

        // Randomized traffic with varying input density and back-pressure.
        for (int blk = 0; blk < 30; blk++) begin
            case (blk % 3)
                0: p = 90;
                1: p = 30;
                default: p = 5;
            endcase
            for (int c = 0; c < 100; c++) begin
                cycle($urandom_range(0, 99) < p, $urandom_range(0, 99) < 85, $urandom,
                      {$urandom_range(0, 1 << 20), 2'b00}, $urandom_range(0, 99) < 8,
                      $urandom_range(0, 1), CAUSE_LEN'($urandom), $urandom,
                      $urandom_range(0, 99) < 65);
            end
        end
        repeat (20) idle(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/retire_packer.md
Name: retire_packer

Overview:
- Inverse of the multi-retire serializer. Takes the single-instruction retirement stream (one instruction per cycle, valid/ready) and packs consecutive instructions into multi-lane retire bundles of up to NrRetiredInstr lanes.
- Each bundle carries per-lane valids, opcodes and PCs, plus one trap record.
- Used as the CPU-side adapter for single-issue cores, and as the stimulus generator that drives the multi-retire ingress in testbenches.

Parameters:
NrRetiredInstr, 2, number of lanes per bundle (>=1)
Timeout, 8, idle cycles with a partial bundle open before forced close; 0 disables the timeout

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
inst_valid_i  in  1  input record valid
ready_o  out  1  input record accepted when inst_valid_i && ready_o
iretired_i  in  1  record carries a retired instruction
inst_data_i  in  mure_pkg::INST_LEN  opcode
pc_i  in  mure_pkg::XLEN  instruction address
exception_i  in  1  trap taken at this record
interrupt_i  in  1  trap is an interrupt; valid only with exception_i
cause_i  in  mure_pkg::CAUSE_LEN  trap cause
tval_i  in  mure_pkg::XLEN  trap value
bundle_valid_o  out  1  bundle present
bundle_ready_i  in  1  bundle consumed when bundle_valid_o && bundle_ready_i
valids_o  out  NrRetiredInstr  per-lane valid
uops_o  out  NrRetiredInstr*mure_pkg::INST_LEN  lane i at bits [i*INST_LEN +: INST_LEN]
pcs_o  out  NrRetiredInstr*mure_pkg::XLEN  lane i at bits [i*XLEN +: XLEN]
exception_o, interrupt_o  out  1 each  bundle trap flags
cause_o  out  mure_pkg::CAUSE_LEN  trap cause
tval_o  out  mure_pkg::XLEN  trap value

Behaviour:
- Reset values:
  - All bundle outputs are 0; bundle_valid_o = 0.
  - Accumulator empty (cnt = 0); state IDLE; idle counter = 0.
  - ready_o = 1, because ready_o is a function of state only.
- States:
  - IDLE: cnt = 0.
  - FILL: 0 < cnt < NrRetiredInstr.
  - CLOSED: bundle complete, waiting for the output register.
- ready_o = (state != CLOSED).
- Lane fill: an accepted record with iretired_i = 1 writes lane cnt and increments cnt. Lanes fill from 0 upward, with no gaps.
- Trap record: trap fields are captured only from records with exception_i = 1. These fields are cleared when the bundle is handed off. A record with iretired_i = 0 and exception_i = 1 occupies no lane.
- Close event, evaluated each cycle:
  - A record is accepted and (new cnt == NrRetiredInstr, or exception_i = 1); or
  - Timeout fires: Timeout != 0, state FILL, no accept this cycle, and idle counter == Timeout-1.
- Output free condition: out_free = !bundle_valid_o || bundle_ready_i.
- Close event with out_free: at that edge the output register loads the merged bundle, including the closing record. bundle_valid_o rises the next cycle (latency 1). The accumulator returns to IDLE.
- Close event without out_free: the merged bundle is held in the accumulator and the state becomes CLOSED.
- CLOSED: on the first cycle with out_free, the output register loads and the state becomes IDLE. ready_o is 1 from the following cycle.
- Idle counter: increments in FILL on cycles with no accept. It clears on accept, on close, and in IDLE.
- Output register: outputs hold stable while bundle_valid_o && !bundle_ready_i. On handshake with no new load, bundle_valid_o drops to 0 and the data is don't-care.
- A trap-only record accepted in IDLE emits a bundle with valids_o = 0 and exception_o = 1.
- interrupt_i without exception_i is ignored.
- Reset asserted mid-bundle discards the accumulator and output register; no partial bundle is emitted.

Optional Feature:
- Macro: RETIRE_PACKER_PERF_EN.
- When defined:
  - Adds outputs bundle_cnt_o (32-bit) and timeout_cnt_o (32-bit), both reset to 0.
  - bundle_cnt_o counts bundles loaded into the output register.
  - timeout_cnt_o counts closes caused by timeout.
  - Both counters wrap modulo 2^32.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- NrRetiredInstr=2, bundle_ready_i=1: records PC 0x100/0x104 on back-to-back cycles -> one bundle, valids_o=2'b11, pcs_o={0x104,0x100}, bundle_valid_o high 1 cycle after the second accept.
- Single record PC 0x200, then idle, Timeout=8 -> bundle with valids_o=2'b01 emitted after 8 idle cycles (timeout_cnt_o=1 with RETIRE_PACKER_PERF_EN).
- Record PC 0x300 with exception_i=1, cause_i=2, tval_i=0xDEAD in lane 0 -> immediate close, valids_o=2'b01, exception_o=1, cause_o=2, tval_o=0xDEAD, interrupt_o=0.
- bundle_ready_i=0 with continuous input -> first bundle held stable; second bundle closes into CLOSED and ready_o=0; on bundle_ready_i=1, bundles emerge in order with no loss or duplication.
- Trap-only record (iretired_i=0, exception_i=1, interrupt_i=1) in IDLE -> bundle with valids_o=0, exception_o=1, interrupt_o=1.
- rst_ni pulsed low while cnt=1 and bundle_valid_o=1 -> all outputs 0 immediately, ready_o=1, no stale lane in the next bundle.
